// File: rtl/cw_husky_pkg.sv
// rtl/cw_husky_pkg.sv - register map, capture FSM states and sample width for the Husky capture top
package cw_husky_pkg;

    localparam int pSAMPLE_W = 12;

    localparam logic [7:0] REG_GAIN       = 8'd0;
    localparam logic [7:0] REG_SETTINGS   = 8'd1;
    localparam logic [7:0] REG_DATA       = 8'd3;
    localparam logic [7:0] REG_ECHO       = 8'd4;
    localparam logic [7:0] REG_PRESAMPLES = 8'd17;
    localparam logic [7:0] REG_DATA_SRC   = 8'd27;
    localparam logic [7:0] REG_SOFT_RESET = 8'd28;
    localparam logic [7:0] REG_LOW_RES    = 8'd29;
    localparam logic [7:0] REG_CFG38      = 8'd38;
    localparam logic [7:0] REG_CFG60      = 8'd60;
    localparam logic [7:0] REG_CFG61      = 8'd61;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/cw_husky_sample_buf.sv
// rtl/cw_husky_sample_buf.sv - circular sample RAM with write/read pointers, fill count and drop-oldest
module cw_husky_sample_buf #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     drop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_adv;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    // A readout pop and a pre-trigger drop both just retire the oldest entry.
    assign do_adv  = (pop || drop) && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_adv);
        end
    end

endmodule

// File: rtl/cw_husky_top.sv
// rtl/cw_husky_top.sv - reduced Husky capture top: USB register bus, arm/trigger FSM, ramp source, packed readout
module cw_husky_top
    import cw_husky_pkg::*;
#(
    parameter int pBUF_DEPTH = 1024
) (
    input  logic       clk_usb,
    input  logic       reset,
    inout  wire  [7:0] USB_Data,
    input  logic [7:0] USB_Addr,
    input  logic       USB_RDn,
    input  logic       USB_WRn,
    input  logic       USB_CEn,
    input  logic       target_io4,
    input  logic       ADC_clk_fbp,
    input  logic       ADC_clk_fbn,
    output logic       ADC_CLKP,
    output logic       ADC_CLKN,
    output logic       LED_ARMED,
    output logic       LED_CAP,
    output logic       LED_CLK1FAIL,
    output logic       LED_CLK2FAIL,
    output logic       FPGA_TRIGOUT,
    inout  wire        target_io1,
    inout  wire        target_io2,
    inout  wire        target_io3,
    inout  wire        USBIOHS2
);

    localparam int CW = $clog2(pBUF_DEPTH) + 1;

    logic [7:0]  addr_s1, addr_s2, data_s1, data_s2;
    logic [2:0]  rdn_sr, wrn_sr, cen_sr;
    logic [1:0]  idx;
    logic [7:0]  gain, settings, echo, data_src, soft_reset, low_res, cfg38, cfg60, cfg61;
    logic [31:0] presamples;
    logic        trig_now;
    logic [7:0]  rd_byte, data_byte;
    logic        wr_commit, rd_done, cen_rise, soft_rst, arm, level;
    logic [11:0] ramp;
    logic        io4_s1, io4_s2, arm_prev, trig_event;
    cap_state_t  state, state_next;
    logic        buf_clr, buf_wr, buf_drop, buf_pop, buf_full, buf_empty, pop_req;
    logic [pSAMPLE_W-1:0] buf_rd;
    logic [CW-1:0] buf_count;
    logic [CW-2:0] pre_eff;
    logic [1:0]  phase;
    logic [3:0]  hold;
    wire         unused_ok = ^{ADC_clk_fbp, ADC_clk_fbn};

    assign ADC_CLKP     = clk_usb;
    assign ADC_CLKN     = ~clk_usb;
    assign LED_CLK1FAIL = 1'b0;
    assign LED_CLK2FAIL = 1'b0;
    assign target_io1   = 1'bz;
    assign target_io2   = 1'bz;
    assign target_io3   = 1'bz;
    assign USBIOHS2     = 1'bz;
    assign USB_Data     = (!USB_CEn && !USB_RDn) ? rd_byte : 8'hzz;

    // Strobe shift registers: [1] is the sampled level, [2] the previous one for edge detection.
    assign wr_commit = wrn_sr[2] && !wrn_sr[1] && !cen_sr[1];
    assign rd_done   = !rdn_sr[2] && rdn_sr[1] && !cen_sr[1];
    assign cen_rise  = !cen_sr[2] && cen_sr[1];
    assign soft_rst  = soft_reset[0];
    assign arm       = settings[3];
    assign level     = settings[2];

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            addr_s1 <= '0;
            addr_s2 <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
            rdn_sr  <= 3'b111;
            wrn_sr  <= 3'b111;
            cen_sr  <= 3'b111;
        end else begin
            addr_s1 <= USB_Addr;
            addr_s2 <= addr_s1;
            data_s1 <= USB_Data;
            data_s2 <= data_s1;
            rdn_sr  <= {rdn_sr[1:0], USB_RDn};
            wrn_sr  <= {wrn_sr[1:0], USB_WRn};
            cen_sr  <= {cen_sr[1:0], USB_CEn};
        end
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            gain       <= '0;
            settings   <= '0;
            echo       <= '0;
            presamples <= '0;
            data_src   <= '0;
            soft_reset <= '0;
            low_res    <= '0;
            cfg38      <= '0;
            cfg60      <= '0;
            cfg61      <= '0;
            trig_now   <= 1'b0;
        end else begin
            trig_now <= 1'b0;
            if (cen_rise) begin
                idx <= '0;
            end else if (wr_commit || rd_done) begin
                idx <= idx + 2'd1;
            end
            if (wr_commit) begin
                case (addr_s2)
                    REG_GAIN:       gain <= data_s2;
                    REG_SETTINGS: begin
                        settings <= data_s2 & 8'hBF;
                        trig_now <= data_s2[6];
                    end
                    REG_ECHO:       echo <= data_s2;
                    REG_PRESAMPLES: presamples[{idx, 3'b000} +: 8] <= data_s2;
                    REG_DATA_SRC:   data_src <= data_s2;
                    REG_SOFT_RESET: soft_reset <= data_s2;
                    REG_LOW_RES:    low_res <= data_s2;
                    REG_CFG38:      cfg38 <= data_s2;
                    REG_CFG60:      cfg60 <= data_s2;
                    REG_CFG61:      cfg61 <= data_s2;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr_s2)
            REG_GAIN:       rd_byte = gain;
            REG_SETTINGS:   rd_byte = settings;
            REG_DATA:       rd_byte = data_byte;
            REG_ECHO:       rd_byte = echo;
            REG_PRESAMPLES: rd_byte = presamples[{idx, 3'b000} +: 8];
            REG_DATA_SRC:   rd_byte = data_src;
            REG_SOFT_RESET: rd_byte = soft_reset;
            REG_LOW_RES:    rd_byte = low_res;
            REG_CFG38:      rd_byte = cfg38;
            REG_CFG60:      rd_byte = cfg60;
            REG_CFG61:      rd_byte = cfg61;
            default:        rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            ramp         <= '0;
            io4_s1       <= 1'b0;
            io4_s2       <= 1'b0;
            arm_prev     <= 1'b0;
            state        <= ST_IDLE;
            FPGA_TRIGOUT <= 1'b0;
        end else begin
            ramp         <= soft_rst ? 12'd0 : ramp + 12'd1;
            io4_s1       <= target_io4;
            io4_s2       <= io4_s1;
            arm_prev     <= arm;
            state        <= state_next;
            FPGA_TRIGOUT <= trig_event;
        end
    end

    assign pre_eff = (presamples > 32'(pBUF_DEPTH - 1)) ? (CW-1)'(pBUF_DEPTH - 1)
                                                         : presamples[CW-2:0];

    always_comb begin
        state_next = state;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;
        buf_drop   = 1'b0;
        trig_event = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm && !arm_prev) begin
                    state_next = ST_PRETRIG;
                    buf_clr    = 1'b1;
                end
            end
            ST_PRETRIG: begin
                buf_wr   = 1'b1;
                buf_drop = (buf_count > {1'b0, pre_eff});
                if (trig_now || (io4_s2 == level)) begin
                    trig_event = 1'b1;
                    state_next = ST_CAPTURE;
                end
            end
            // Leaves on the cycle after the last write makes the buffer full.
            ST_CAPTURE: begin
                buf_wr = 1'b1;
                if (buf_full) begin
                    state_next = ST_DONE;
                end
            end
            default: ;
        endcase
        if (!arm) begin
            state_next = ST_IDLE;
        end
        if (soft_rst) begin
            state_next = ST_IDLE;
            buf_clr    = 1'b1;
            buf_wr     = 1'b0;
            buf_drop   = 1'b0;
            trig_event = 1'b0;
        end
    end

    assign LED_ARMED = (state == ST_PRETRIG);
    assign LED_CAP   = (state == ST_CAPTURE);

    cw_husky_sample_buf #(
        .DEPTH (pBUF_DEPTH),
        .WIDTH (pSAMPLE_W)
    ) u_buf (
        .clk     (clk_usb),
        .rst     (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data ((data_src == 8'd0) ? ramp : 12'd0),
        .pop     (buf_pop),
        .drop    (buf_drop),
        .rd_data (buf_rd),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign pop_req = rd_done && (addr_s2 == REG_DATA) && !buf_empty;

    // 12-bit mode: phase 0 pops a and keeps its low nibble, phase 1 peeks b, phase 2 pops b.
    always_comb begin
        data_byte = 8'h00;
        buf_pop   = 1'b0;
        if (!buf_empty) begin
            if (low_res != 8'd0) begin
                data_byte = buf_rd[7:0];
                buf_pop   = pop_req;
            end else begin
                case (phase)
                    2'd0: begin
                        data_byte = buf_rd[11:4];
                        buf_pop   = pop_req;
                    end
                    2'd1: data_byte = {hold, buf_rd[11:8]};
                    default: begin
                        data_byte = buf_rd[7:0];
                        buf_pop   = pop_req;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            phase <= '0;
            hold  <= '0;
        end else if (soft_rst) begin
            phase <= '0;
        end else if (pop_req && (low_res == 8'd0)) begin
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            if (phase == 2'd0) begin
                hold <= buf_rd[3:0];
            end
        end
    end

endmodule

// File: tb/tb_cw_husky_top.sv
// tb/tb_cw_husky_top.sv - directed self-checking bench for cw_husky_top
module tb_cw_husky_top;

    logic       clk_usb = 1'b0;
    logic       reset;
    wire  [7:0] USB_Data;
    logic [7:0] USB_Addr;
    logic       USB_RDn, USB_WRn, USB_CEn;
    logic       target_io4;
    logic [7:0] drv_data;
    logic       drv_en;
    logic       ADC_CLKP, ADC_CLKN, LED_ARMED, LED_CAP, LED_CLK1FAIL, LED_CLK2FAIL, FPGA_TRIGOUT;
    wire        target_io1, target_io2, target_io3, USBIOHS2;

    int n_checks = 0;
    int n_fail   = 0;
    int cap_cycles = 0;
    int trig_pulses = 0;

    assign USB_Data = drv_en ? drv_data : 8'hzz;

    always #5 clk_usb = ~clk_usb;

    always @(negedge clk_usb) begin
        if (LED_CAP) cap_cycles++;
        if (FPGA_TRIGOUT) trig_pulses++;
    end

    cw_husky_top dut (
        .clk_usb      (clk_usb),
        .reset        (reset),
        .USB_Data     (USB_Data),
        .USB_Addr     (USB_Addr),
        .USB_RDn      (USB_RDn),
        .USB_WRn      (USB_WRn),
        .USB_CEn      (USB_CEn),
        .target_io4   (target_io4),
        .ADC_clk_fbp  (1'b0),
        .ADC_clk_fbn  (1'b1),
        .ADC_CLKP     (ADC_CLKP),
        .ADC_CLKN     (ADC_CLKN),
        .LED_ARMED    (LED_ARMED),
        .LED_CAP      (LED_CAP),
        .LED_CLK1FAIL (LED_CLK1FAIL),
        .LED_CLK2FAIL (LED_CLK2FAIL),
        .FPGA_TRIGOUT (FPGA_TRIGOUT),
        .target_io1   (target_io1),
        .target_io2   (target_io2),
        .target_io3   (target_io3),
        .USBIOHS2     (USBIOHS2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wait(input int n);
        repeat (n) @(posedge clk_usb);
        #1;
    endtask

    task automatic cs(input logic v);
        USB_CEn = v;
        bus_wait(4);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        USB_Addr = a;
        drv_data = d;
        drv_en   = 1'b1;
        bus_wait(3);
        USB_WRn = 1'b0;
        bus_wait(4);
        USB_WRn = 1'b1;
        bus_wait(3);
        drv_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        USB_Addr = a;
        bus_wait(3);
        USB_RDn = 1'b0;
        bus_wait(4);
        d = USB_Data;
        USB_RDn = 1'b1;
        bus_wait(3);
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        cs(1'b0);
        wr(a, d);
        cs(1'b1);
    endtask

    task automatic rd1(input logic [7:0] a, output logic [7:0] d);
        cs(1'b0);
        rd(a, d);
        cs(1'b1);
    endtask

    task automatic wr_presamples(input logic [31:0] v);
        cs(1'b0);
        for (int i = 0; i < 4; i++) wr(8'd17, v[8*i +: 8]);
        cs(1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d, b0, b1, b2;
        logic [7:0]  prev8;
        logic [11:0] prev12, sa, sb;
        int          cap0, trig0;

        reset = 1'b1; USB_Addr = 8'd0; USB_RDn = 1'b1; USB_WRn = 1'b1; USB_CEn = 1'b1;
        target_io4 = 1'b0; drv_data = 8'd0; drv_en = 1'b0;
        bus_wait(3);
        reset = 1'b0;
        bus_wait(2);

        check("rst_armed", LED_ARMED, 0);
        check("rst_cap", LED_CAP, 0);
        check("rst_trigout", FPGA_TRIGOUT, 0);
        check("rst_clkfail", {LED_CLK1FAIL, LED_CLK2FAIL}, 0);
        rd1(8'd3, d);    check("rst_empty_data", d, 8'h00);
        rd1(8'd1, d);    check("rst_settings", d, 8'h00);

        wr1(8'd4, 8'hA5);  rd1(8'd4, d);  check("echo", d, 8'hA5);
        wr1(8'd0, 8'h7F);  rd1(8'd0, d);  check("gain", d, 8'h7F);
        wr1(8'd38, 8'h3C); rd1(8'd38, d); check("cfg38", d, 8'h3C);
        wr1(8'd5, 8'h55);  rd1(8'd5, d);  check("unmapped", d, 8'h00);

        wr_presamples(32'hDEADBE10);
        cs(1'b0);
        rd(8'd17, d); check("pre_b0", d, 8'h10);
        rd(8'd17, d); check("pre_b1", d, 8'hBE);
        rd(8'd17, d); check("pre_b2", d, 8'hAD);
        rd(8'd17, d); check("pre_b3", d, 8'hDE);
        cs(1'b1);

        // 8-bit readout, trigger-now.
        wr1(8'd29, 8'd3);
        wr_presamples(32'd0);
        wr1(8'd1, 8'h0C);
        bus_wait(20);
        check("t1_armed", LED_ARMED, 1);
        check("t1_not_cap", LED_CAP, 0);
        wr1(8'd1, 8'h48);
        rd1(8'd1, d); check("t1_trignow_clears", d, 8'h08);
        check("t1_trig_pulse", trig_pulses, 1);
        cs(1'b0);
        rd(8'd3, prev8);
        for (int i = 1; i < 90; i++) begin
            rd(8'd3, d);
            check("t1_ramp8", d, prev8 + 8'd1);
            prev8 = d;
        end
        cs(1'b1);
        wr1(8'd1, 8'h00);
        check("t1_disarm", LED_ARMED | LED_CAP, 0);

        // 12-bit packed readout, trigger via target_io4.
        wr1(8'd29, 8'd0);
        wr1(8'd1, 8'h0C);
        bus_wait(10);
        check("t2_armed", LED_ARMED, 1);
        target_io4 = 1'b1;
        bus_wait(5);
        target_io4 = 1'b0;
        check("t2_cap", LED_CAP, 1);
        check("t2_trig_pulse", trig_pulses, 2);
        cs(1'b0);
        prev12 = 12'd0;
        for (int k = 0; k < 45; k++) begin
            rd(8'd3, b0); rd(8'd3, b1); rd(8'd3, b2);
            sa = {b0, b1[7:4]};
            sb = {b1[3:0], b2};
            if (k != 0) check("t2_ramp12_a", sa, prev12 + 12'd1);
            check("t2_ramp12_b", sb, sa + 12'd1);
            prev12 = sb;
        end
        cs(1'b1);
        wr1(8'd1, 8'h00);

        // Pre-trigger retention: 17 held samples, 1007 capture writes plus the full-detect cycle.
        wr1(8'd29, 8'd1);
        wr_presamples(32'd16);
        wr1(8'd1, 8'h0C);
        bus_wait(200);
        cap0 = cap_cycles;
        wr1(8'd1, 8'h4C);
        bus_wait(2000);
        check("t3_cap_cycles", cap_cycles - cap0, 1008);
        check("t3_done", LED_CAP | LED_ARMED, 0);
        cs(1'b0);
        rd(8'd3, prev8);
        for (int i = 1; i < 1024; i++) begin
            rd(8'd3, d);
            if (d !== prev8 + 8'd1) check("t3_contig", d, prev8 + 8'd1);
            prev8 = d;
        end
        check("t3_last_contig", d, prev8);
        rd(8'd3, d); check("t3_past_depth0", d, 8'h00);
        rd(8'd3, d); check("t3_past_depth1", d, 8'h00);
        cs(1'b1);

        // Soft reset mid-capture.
        wr1(8'd1, 8'h00);
        wr1(8'd1, 8'h0C);
        bus_wait(50);
        wr1(8'd1, 8'h4C);
        bus_wait(20);
        check("t4_cap", LED_CAP, 1);
        wr1(8'd28, 8'h01);
        check("t4_idle", LED_CAP | LED_ARMED, 0);
        rd1(8'd3, d);  check("t4_buf_empty", d, 8'h00);
        rd1(8'd0, d);  check("t4_gain_kept", d, 8'h7F);
        rd1(8'd1, d);  check("t4_settings_kept", d, 8'h0C);
        rd1(8'd4, d);  check("t4_echo_kept", d, 8'hA5);
        rd1(8'd28, d); check("t4_softreset_rd", d, 8'h01);
        wr1(8'd28, 8'h00);

        // Level high, pin low, no trigger-now: must sit in PRETRIG.
        wr1(8'd1, 8'h00);
        trig0 = trig_pulses;
        wr1(8'd1, 8'h0C);
        bus_wait(300);
        check("t5_armed", LED_ARMED, 1);
        check("t5_no_cap", LED_CAP, 0);
        check("t5_no_trigout", FPGA_TRIGOUT, 0);
        check("t5_no_pulse", trig_pulses - trig0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
